// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: spin FSM state encoding, selector speed
// constants and the saturating ramp arithmetic used by the spin controller.
package wm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    FINISH    = 3'd4
  } spin_state_t;

  localparam logic [10:0] SPEED_400  = 11'd400;
  localparam logic [10:0] SPEED_800  = 11'd800;
  localparam logic [10:0] SPEED_1200 = 11'd1200;
  localparam logic [10:0] SPEED_1400 = 11'd1400;

  // Sum is formed in 12 bits so targets near 2047 cannot wrap past the clamp.
  function automatic logic [10:0] ramp_up_step(input logic [10:0] cmd,
                                               input logic [10:0] step,
                                               input logic [10:0] tgt);
    logic [11:0] sum;
    sum = {1'b0, cmd} + {1'b0, step};
    return (sum >= {1'b0, tgt}) ? tgt : sum[10:0];
  endfunction

  function automatic logic [10:0] ramp_down_step(input logic [10:0] cmd,
                                                 input logic [10:0] step);
    return (cmd <= step) ? 11'd0 : (cmd - step);
  endfunction

endpackage

// File: rtl/spin_tick_gen.sv
// Ramp/hold tick divider: one-cycle tick every DIV enabled cycles, counter
// frozen while disabled and zeroed by clr.
module spin_tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/spin_ramp_controller.sv
// Spin-phase sequencer: ramp motor command up to the latched target, hold,
// ramp down, pulse done. Optional imbalance trip under SPIN_IMBALANCE_CHECK_EN.
module spin_ramp_controller
  import wm_pkg::*;
#(
  parameter logic [10:0] RAMP_STEP  = 11'd100,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned HOLD_TICKS = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        door_open,
  input  logic [10:0] target_speed,
  output logic [10:0] motor_rpm_cmd,
  output logic        busy,
  output logic        done,
  output logic [2:0]  spin_state
`ifdef SPIN_IMBALANCE_CHECK_EN
  ,
  input  logic        imbalance,
  output logic        imbalance_fault
`endif
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  spin_state_t   state_q, state_d;
  logic [10:0]   cmd_q, cmd_d;
  logic [10:0]   tgt_q, tgt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          busy_q, done_q;
  logic          tick, tick_en, tick_clr;
  logic          stop_req;
  logic          start_ok;

`ifdef SPIN_IMBALANCE_CHECK_EN
  logic fault_q, fault_d;
  assign stop_req = abort | door_open | imbalance;
`else
  assign stop_req = abort | door_open;
`endif

  assign start_ok = start && !abort && !door_open;
  assign tick_en  = (state_q == RAMP_UP) || (state_q == HOLD) || (state_q == RAMP_DOWN);

  spin_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    tgt_d    = tgt_q;
    hold_d   = hold_q;
    tick_clr = 1'b0;
`ifdef SPIN_IMBALANCE_CHECK_EN
    fault_d  = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          tgt_d    = target_speed;
          hold_d   = '0;
          tick_clr = 1'b1;
`ifdef SPIN_IMBALANCE_CHECK_EN
          fault_d  = 1'b0;
`endif
          state_d  = (target_speed == 11'd0) ? FINISH : RAMP_UP;
        end
      end
      RAMP_UP: begin
        // A stop request wins over a coincident tick; cmd moves on the next tick.
        if (stop_req) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          cmd_d = ramp_up_step(cmd_q, RAMP_STEP, tgt_q);
          if (cmd_d == tgt_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop_req) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) state_d = RAMP_DOWN;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          cmd_d = ramp_down_step(cmd_q, RAMP_STEP);
          if (cmd_d == 11'd0) state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef SPIN_IMBALANCE_CHECK_EN
    if (imbalance && ((state_q == RAMP_UP) || (state_q == HOLD))) fault_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      tgt_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FINISH);
    end
  end

`ifdef SPIN_IMBALANCE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign imbalance_fault = fault_q;
`endif

  assign motor_rpm_cmd = cmd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign spin_state    = state_q;

endmodule

// File: doc/spin_ramp_controller.md
# spin_ramp_controller

Sequences the spin phase of a wash cycle. It takes the spin speed chosen by the spin-speed selector, ramps the motor speed command up to it in fixed steps, holds it for a programmed time, then ramps back down to zero. It sits between the spin-speed selector and the motor drive interface, and reports busy/done to the top-level wash sequencer.

## Interface
- `RAMP_STEP`, 11'd100: rpm added to or subtracted from the command per ramp tick.
- `TICK_DIV`, 1000: clk cycles per ramp/hold tick (≥2).
- `HOLD_TICKS`, 600: ticks spent at target speed (≥1).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin a spin phase; sampled only in IDLE.
- `abort`  in  1  request controlled ramp-down; level-sensitive.
- `door_open`  in  1  door interlock; treated exactly like `abort`.
- `target_speed`  in  11  requested rpm; 400/800/1200/1400 in normal use.
- `motor_rpm_cmd`  out  11  registered speed command to the motor drive.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse when the phase finishes or the abort ramp-down completes.
- `spin_state`  out  3  current state encoding, for debug and the sequencer.

## Operation
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, FINISH.
- IDLE:
  - On `start`=1 with `abort`=0 and `door_open`=0: latch `target_speed` into `tgt`, clear the tick divider and hold counter, go to RAMP_UP.
  - `start` while `abort` or `door_open` is high is ignored.
  - If the latched `tgt` is 0, go directly to FINISH instead.
- RAMP_UP, on each tick:
  - `cmd` = min(`cmd`+`RAMP_STEP`, `tgt`), computed in 12 bits to avoid overflow.
  - When `cmd`==`tgt` after the update, go to HOLD.
- HOLD:
  - Count ticks. After `HOLD_TICKS` ticks, go to RAMP_DOWN.
  - `cmd` stays equal to `tgt`.
- RAMP_DOWN, on each tick:
  - `cmd` = (`cmd` ≤ `RAMP_STEP`) ? 0 : `cmd`−`RAMP_STEP`.
  - When `cmd` reaches 0, go to FINISH.
- FINISH: assert `done` for one cycle, go to IDLE.
- Abort: `abort` or `door_open` high in RAMP_UP or HOLD moves the FSM to RAMP_DOWN on the next clk edge. The ramp-down starts from the current `cmd`.
  - Abort in RAMP_DOWN has no extra effect.
  - Abort ramp-down still ends with a `done` pulse.
- `start` outside IDLE is ignored. `target_speed` changes after latch are ignored until the next start.

## Timing
- Reset values: `motor_rpm_cmd`=0, `busy`=0, `done`=0, `spin_state`=IDLE. The tick divider, hold counter and `tgt` are also cleared.
- Reset asserted mid-operation forces all of the above immediately; no ramp-down is performed.
- Tick divider:
  - Free-runs only while in RAMP_UP, HOLD or RAMP_DOWN.
  - Produces a tick every `TICK_DIV` cycles, the first one `TICK_DIV` cycles after entering RAMP_UP.
  - Is not cleared on abort.
- Start latency: `start` is sampled at edge N. At N+1, `busy`=1 and `spin_state`=RAMP_UP.
- All `cmd` changes and tick-based state changes take effect at the edge where the tick is high.
- Abort latency: one cycle for the state change. `cmd` decrements on the next tick.
- `done` is high exactly one cycle, in FINISH. IDLE follows, with `busy`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SPIN_IMBALANCE_CHECK_EN` defined:
  - Adds input `imbalance` (1 bit) and output `imbalance_fault` (1 bit, reset 0).
  - `imbalance` high in RAMP_UP or HOLD sets `imbalance_fault` and forces RAMP_DOWN, with the same timing as abort.
  - `imbalance_fault` stays set until the next accepted `start`, which clears it.
- `SPIN_IMBALANCE_CHECK_EN` undefined: neither port exists and there is no imbalance logic.

## Structure
- Shared package `wm_pkg`:
  - `spin_state_t` enum (IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, FINISH=4).
  - Speed constants `SPEED_400`, `SPEED_800`, `SPEED_1200`, `SPEED_1400`, shared with the speed selector.
- One sub-module, `spin_tick_gen`: parameterised divider with `en`/`clr` inputs and a `tick` output. The FSM and ramp arithmetic stay in the top module.

## Test plan
Bench parameters for all scenarios: `TICK_DIV`=4, `RAMP_STEP`=400, `HOLD_TICKS`=2.
- Normal run: start with target 1400.
  - `cmd` sequence 400, 800, 1200, 1400.
  - Held for 2 ticks, then 1000, 600, 200, 0.
  - `done` pulses once; `busy` is high from start+1 until FINISH.
- Saturation and boundary targets:
  - Target 1000 → `cmd` 400, 800, 1000, then 600, 200, 0.
  - Target 0 → FINISH the cycle after IDLE, `done` pulses, `cmd` stays 0.
- Abort in RAMP_UP at `cmd`=800: RAMP_DOWN next cycle; `cmd` then 400, 0; `done` pulses.
  - Repeat using `door_open` instead of `abort`; same response.
- Start ignored:
  - `start` pulsed during HOLD → no restart, and the latched target is unchanged when `target_speed` differs.
  - `start` in IDLE with `door_open`=1 → stays IDLE.
- Async reset during HOLD at `cmd`=1400: `cmd`=0, `busy`=0, IDLE with no clock edge needed; a subsequent start works normally.
- With `SPIN_IMBALANCE_CHECK_EN`:
  - `imbalance` pulse in HOLD → `imbalance_fault`=1, ramp-down to 0, `done` pulses.
  - Fault stays high until the next start.
